packing_length_ctrl: RTL

- Parametrised successor to the stage-1/2 length accumulator. Tracks compressed bit lengths per cache line, emits one word event each time WORD_SIZE bits are packed, and pads and flushes the final partial word on end-of-line.
- Detects line overflow (compressed > CACHE_LINE) and drains the rest of the line so the line can be sent uncompressed.
- Sits between the per-word compressor length output and the Reg1/Reg2 shift/pack datapath, using valid/ready handshakes on both sides.

---
 rtl/packing_length_ctrl_pkg.sv | 9 +
 rtl/packing_length_ctrl_if.sv | 29 ++
 rtl/packing_length_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/packing_length_ctrl_pkg.sv
// packing_len_pkg: shared FSM states, default geometry and counter-width helper for the length packer.
package packing_len_pkg;
  typedef enum logic [2:0] {ACCUM, EMIT, FLUSH, DRAIN, DONE} state_t;
  localparam int WORD_SIZE_D = 64;
  localparam int CACHE_LINE_D = 128;
  function automatic int cnt_w(input int v, input int extra);
    return $clog2(v) + extra;
  endfunction
endpackage

// File: rtl/packing_length_ctrl_if.sv
// packing_length_ctrl_if: length-beat input handshake and packed-word/line-status output bundle.
interface packing_length_ctrl_if import packing_len_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int CACHE_LINE = CACHE_LINE_D,
  parameter int LEN_W = 7
);
  localparam int PW = cnt_w(WORD_SIZE, 1);
  localparam int TW = cnt_w(CACHE_LINE, 2);
  logic i_valid;
  logic o_ready;
  logic [LEN_W-1:0] i_length;
  logic i_last;
  logic o_word_valid;
  logic i_word_ready;
  logic [PW-1:0] o_shift_amount;
  logic [PW-1:0] o_pad_bits;
  logic o_word_last;
  logic o_line_done;
  logic o_overflow;
  logic [TW-1:0] o_total_bits;
  modport slave (
    input i_valid, i_length, i_last, i_word_ready,
    output o_ready, o_word_valid, o_shift_amount, o_pad_bits, o_word_last, o_line_done, o_overflow, o_total_bits
  );
  modport master (
    output i_valid, i_length, i_last, i_word_ready,
    input o_ready, o_word_valid, o_shift_amount, o_pad_bits, o_word_last, o_line_done, o_overflow, o_total_bits
  );
endinterface

// File: rtl/packing_length_ctrl.sv
// packing_length_ctrl: accumulates per-beat compressed lengths, emits one event per packed word,
// flushes the padded tail word at end of line and drains lines that overflow CACHE_LINE.
module packing_length_ctrl import packing_len_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int CACHE_LINE = CACHE_LINE_D,
  parameter int LEN_W = 7
) (
  input logic i_clk,
  input logic i_reset,
  packing_length_ctrl_if.slave bus
);
  localparam int PW = cnt_w(WORD_SIZE, 1);
  localparam int TW = cnt_w(CACHE_LINE, 2);
  localparam logic [PW-1:0] WS = PW'(WORD_SIZE);
  localparam logic [TW-1:0] CL = TW'(CACHE_LINE);
  state_t state;
  logic [PW-1:0] partial, np;
  logic [TW-1:0] total, nt;
  logic pend, acc;
  // partial < WORD_SIZE and length <= WORD_SIZE, so np always fits in PW bits
  assign np = partial + PW'(bus.i_length);
  assign nt = total + TW'(bus.i_length);
  assign bus.o_ready = i_reset && (state == ACCUM || state == DRAIN);
  assign acc = bus.i_valid && bus.o_ready;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= ACCUM;
      partial <= '0;
      total <= '0;
      pend <= 1'b0;
      bus.o_word_valid <= 1'b0;
      bus.o_shift_amount <= '0;
      bus.o_pad_bits <= '0;
      bus.o_word_last <= 1'b0;
      bus.o_line_done <= 1'b0;
      bus.o_overflow <= 1'b0;
      bus.o_total_bits <= '0;
    end else
      case (state)
        ACCUM: if (acc) begin
          if (nt > CL) begin
            state <= bus.i_last ? DONE : DRAIN;
            bus.o_line_done <= bus.i_last;
            bus.o_overflow <= bus.i_last;
            bus.o_total_bits <= bus.i_last ? total : '0;
          end else if (np >= WS) begin
            partial <= np - WS;
            total <= nt;
            pend <= bus.i_last;
            state <= EMIT;
            bus.o_word_valid <= 1'b1;
            bus.o_shift_amount <= np;
            bus.o_pad_bits <= '0;
            bus.o_word_last <= bus.i_last && (np == WS);
          end else begin
            partial <= np;
            total <= nt;
            if (bus.i_last && np != '0) begin
              state <= FLUSH;
              bus.o_word_valid <= 1'b1;
              bus.o_shift_amount <= np;
              bus.o_pad_bits <= WS - np;
              bus.o_word_last <= 1'b1;
            end else if (bus.i_last) begin
              state <= DONE;
              bus.o_line_done <= 1'b1;
              bus.o_total_bits <= nt;
            end
          end
        end
        EMIT: if (bus.i_word_ready) begin
          if (pend && partial != '0) begin
            state <= FLUSH;
            bus.o_shift_amount <= partial;
            bus.o_pad_bits <= WS - partial;
            bus.o_word_last <= 1'b1;
          end else begin
            state <= pend ? DONE : ACCUM;
            bus.o_word_valid <= 1'b0;
            bus.o_shift_amount <= '0;
            bus.o_word_last <= 1'b0;
            bus.o_line_done <= pend;
            bus.o_total_bits <= pend ? total : '0;
          end
        end
        FLUSH: if (bus.i_word_ready) begin
          state <= DONE;
          bus.o_word_valid <= 1'b0;
          bus.o_shift_amount <= '0;
          bus.o_pad_bits <= '0;
          bus.o_word_last <= 1'b0;
          bus.o_line_done <= 1'b1;
          bus.o_total_bits <= total;
        end
        DRAIN: if (acc && bus.i_last) begin
          state <= DONE;
          bus.o_line_done <= 1'b1;
          bus.o_overflow <= 1'b1;
          bus.o_total_bits <= total;
        end
        DONE: begin
          state <= ACCUM;
          partial <= '0;
          total <= '0;
          pend <= 1'b0;
          bus.o_line_done <= 1'b0;
          bus.o_overflow <= 1'b0;
          bus.o_total_bits <= '0;
        end
        default: state <= ACCUM;
      endcase
  a_len: assert property (@(posedge i_clk) disable iff (!i_reset)
    bus.i_valid |-> int'(bus.i_length) <= WORD_SIZE);
  a_hold: assert property (@(posedge i_clk) disable iff (!i_reset)
    bus.o_word_valid && !bus.i_word_ready |=> bus.o_word_valid && $stable(bus.o_shift_amount)
      && $stable(bus.o_pad_bits) && $stable(bus.o_word_last));
  a_pulse: assert property (@(posedge i_clk) disable iff (!i_reset)
    bus.o_line_done |=> !bus.o_line_done);
endmodule
